// File: rtl/peripheral_msi_ahb4_pkg.sv
// Shared AHB transfer encodings and arbiter state type for the QoS slave-port
// arbiter and its helpers.
package peripheral_msi_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OWNED  = 2'b01,
        ST_LOCKED = 2'b10
    } arb_state_e;

endpackage

// File: rtl/peripheral_msi_rr_select_ahb4.sv
// Round-robin pick: the first pending master strictly after the one-hot 'last',
// wrapping around; returns one-hot (all zero when nothing is pending).
module peripheral_msi_rr_select_ahb4 #(
    parameter int N = 5
) (
    input  logic [N-1:0] pending,
    input  logic [N-1:0] last,
    output logic [N-1:0] next
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_idx;

    always_comb begin
        last_idx = '0;
        for (int n = 0; n < N; n++) begin
            if (last[n]) last_idx = IW'(n);
        end
    end

    // Walk from the farthest candidate inwards so the nearest one wins.
    always_comb begin
        next = '0;
        for (int k = N; k >= 1; k--) begin
            if (pending[IW'((int'(last_idx) + k) % N)]) begin
                next = N'(1) << ((int'(last_idx) + k) % N);
            end
        end
    end

endmodule

// File: rtl/peripheral_msi_slave_port_qos_ahb4.sv
// Multi-master AHB slave-port arbiter: priority with per-level round-robin,
// age-based starvation promotion, lock retention and one-cycle grant latency.
module peripheral_msi_slave_port_qos_ahb4
    import peripheral_msi_ahb4_pkg::*;
#(
    parameter int PLEN      = 64,
    parameter int XLEN      = 64,
    parameter int MASTERS   = 5,
    parameter int PRIO_BITS = 3,
    parameter int AGE_LIMIT = 15
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic [MASTERS-1:0][PRIO_BITS-1:0] mstpriority,
    input  logic [MASTERS-1:0]                mstHSEL,
    input  logic [MASTERS-1:0][PLEN-1:0]      mstHADDR,
    input  logic [MASTERS-1:0][XLEN-1:0]      mstHWDATA,
    input  logic [MASTERS-1:0]                mstHWRITE,
    input  logic [MASTERS-1:0][2:0]           mstHSIZE,
    input  logic [MASTERS-1:0][2:0]           mstHBURST,
    input  logic [MASTERS-1:0][3:0]           mstHPROT,
    input  logic [MASTERS-1:0][1:0]           mstHTRANS,
    input  logic [MASTERS-1:0]                mstHMASTLOCK,
    input  logic [MASTERS-1:0]                mstHREADY,
    output logic [XLEN-1:0]                   mstHRDATA,
    output logic                              mstHREADYOUT,
    output logic                              mstHRESP,
    output logic                              slv_HSEL,
    output logic [PLEN-1:0]                   slv_HADDR,
    output logic [XLEN-1:0]                   slv_HWDATA,
    output logic                              slv_HWRITE,
    output logic [2:0]                        slv_HSIZE,
    output logic [2:0]                        slv_HBURST,
    output logic [3:0]                        slv_HPROT,
    output logic [1:0]                        slv_HTRANS,
    output logic                              slv_HMASTLOCK,
    output logic                              slv_HREADYOUT,
    input  logic [XLEN-1:0]                   slv_HRDATA,
    input  logic                              slv_HREADY,
    input  logic                              slv_HRESP,
    input  logic [MASTERS-1:0]                can_switch,
    output logic [MASTERS-1:0]                granted_master,
    output logic [MASTERS-1:0]                starved
);
    localparam int IW     = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int LVL_W  = PRIO_BITS + 1;
    localparam int LEVELS = (1 << PRIO_BITS) + 1;
    localparam int AW     = $clog2(AGE_LIMIT + 1);
    localparam logic [LVL_W-1:0] STARVED_LVL = LVL_W'(1 << PRIO_BITS);
    localparam logic [AW-1:0]    AGE_MAX     = AW'(AGE_LIMIT);

    arb_state_e         state_q, state_d;
    logic [MASTERS-1:0] granted_q, granted_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      widx_q, widx_d;
    logic               first_q, first_d;

    logic [MASTERS-1:0][LVL_W-1:0] eff;
    logic [LEVELS-1:0][MASTERS-1:0] last_rec;
    logic [LVL_W-1:0]   top_lvl;
    logic [MASTERS-1:0] cand, rr_next, pending;
    logic               any_req, grant_upd, grant_chg;
    logic [1:0]         trans_raw;

    genvar gi;

    // Starved masters sit one level above every programmable priority.
    generate
        for (gi = 0; gi < MASTERS; gi++) begin : g_mst
            logic [AW-1:0] age_q, age_d;

            assign starved[gi] = (age_q == AGE_MAX);
            assign eff[gi]     = starved[gi] ? STARVED_LVL : {1'b0, mstpriority[gi]};

            always_comb begin
                age_d = age_q;
                if (!mstHSEL[gi] || granted_q[gi]) age_d = '0;
                else if (age_q != AGE_MAX)         age_d = age_q + 1'b1;
            end

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) age_q <= '0;
                else          age_q <= age_d;
            end
        end

        for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
            logic [MASTERS-1:0] rec_q, rec_d;

            always_comb begin
                rec_d = rec_q;
                if (grant_upd && any_req && (top_lvl == LVL_W'(gi))) rec_d = pending;
            end

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) rec_q <= MASTERS'(1);
                else          rec_q <= rec_d;
            end

            assign last_rec[gi] = rec_q;
        end
    endgenerate

    always_comb begin
        any_req = |mstHSEL;
        top_lvl = '0;
        for (int n = 0; n < MASTERS; n++) begin
            if (mstHSEL[n] && (eff[n] > top_lvl)) top_lvl = eff[n];
        end
        cand = '0;
        for (int n = 0; n < MASTERS; n++) begin
            cand[n] = mstHSEL[n] && (eff[n] == top_lvl);
        end
    end

    peripheral_msi_rr_select_ahb4 #(
        .N (MASTERS)
    ) u_rr (
        .pending (cand),
        .last    (last_rec[top_lvl]),
        .next    (rr_next)
    );

    assign pending   = any_req ? rr_next : granted_q;
    assign trans_raw = mstHTRANS[gidx_q];

    always_comb begin
        grant_upd = slv_HREADY && (state_q != ST_LOCKED) &&
                    (can_switch[gidx_q] || (state_q == ST_IDLE));
        grant_chg = grant_upd && (pending != granted_q);
        granted_d = grant_upd ? pending : granted_q;
        gidx_d    = '0;
        for (int n = 0; n < MASTERS; n++) begin
            if (granted_d[n]) gidx_d = IW'(n);
        end
        widx_d  = slv_HREADY ? gidx_q : widx_q;
        first_d = first_q;
        if (grant_chg) begin
            first_d = 1'b1;
        end else if (slv_HREADY && slv_HSEL &&
                     (trans_raw != HTRANS_IDLE) && (trans_raw != HTRANS_BUSY)) begin
            first_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOCKED: if (slv_HREADY && !slv_HMASTLOCK) state_d = ST_OWNED;
            default: begin
                if (slv_HREADY && slv_HMASTLOCK) state_d = ST_LOCKED;
                else if (!slv_HSEL)              state_d = ST_IDLE;
                else                             state_d = ST_OWNED;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            granted_q <= MASTERS'(1);
            gidx_q    <= '0;
            widx_q    <= '0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            granted_q <= granted_d;
            gidx_q    <= gidx_d;
            widx_q    <= widx_d;
            first_q   <= first_d;
        end
    end

    // A new owner continuing a burst must restart it as NONSEQ at the slave.
    assign slv_HTRANS     = (first_q && (trans_raw == HTRANS_SEQ)) ? HTRANS_NONSEQ : trans_raw;
    assign slv_HSEL       = mstHSEL[gidx_q];
    assign slv_HADDR      = mstHADDR[gidx_q];
    assign slv_HWRITE     = mstHWRITE[gidx_q];
    assign slv_HSIZE      = mstHSIZE[gidx_q];
    assign slv_HBURST     = mstHBURST[gidx_q];
    assign slv_HPROT      = mstHPROT[gidx_q];
    assign slv_HMASTLOCK  = mstHMASTLOCK[gidx_q];
    assign slv_HREADYOUT  = mstHREADY[gidx_q];
    assign slv_HWDATA     = mstHWDATA[widx_q];
    assign mstHRDATA      = slv_HRDATA;
    assign mstHREADYOUT   = slv_HREADY;
    assign mstHRESP       = slv_HRESP;
    assign granted_master = granted_q;

endmodule

// File: tb/tb_peripheral_msi_slave_port_qos_ahb4.sv
// Directed scenarios plus randomized traffic against a cycle-level reference
// model of the arbiter built from integer grant/age/lock bookkeeping.
module tb_peripheral_msi_slave_port_qos_ahb4;
    localparam int PLEN = 64;
    localparam int XLEN = 64;
    localparam int M    = 5;
    localparam int PB   = 3;
    localparam int AL   = 15;
    localparam int NLVL = (1 << PB) + 1;

    logic                   HCLK = 1'b0;
    logic                   HRESETn = 1'b0;
    logic [M-1:0][PB-1:0]   mstpriority;
    logic [M-1:0]           mstHSEL;
    logic [M-1:0][PLEN-1:0] mstHADDR;
    logic [M-1:0][XLEN-1:0] mstHWDATA;
    logic [M-1:0]           mstHWRITE;
    logic [M-1:0][2:0]      mstHSIZE;
    logic [M-1:0][2:0]      mstHBURST;
    logic [M-1:0][3:0]      mstHPROT;
    logic [M-1:0][1:0]      mstHTRANS;
    logic [M-1:0]           mstHMASTLOCK;
    logic [M-1:0]           mstHREADY;
    logic [XLEN-1:0]        mstHRDATA;
    logic                   mstHREADYOUT, mstHRESP;
    logic                   slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADYOUT;
    logic [PLEN-1:0]        slv_HADDR;
    logic [XLEN-1:0]        slv_HWDATA;
    logic [2:0]             slv_HSIZE, slv_HBURST;
    logic [3:0]             slv_HPROT;
    logic [1:0]             slv_HTRANS;
    logic [XLEN-1:0]        slv_HRDATA;
    logic                   slv_HREADY, slv_HRESP;
    logic [M-1:0]           can_switch, granted_master, starved;

    always #5 HCLK = ~HCLK;

    peripheral_msi_slave_port_qos_ahb4 #(
        .PLEN(PLEN), .XLEN(XLEN), .MASTERS(M), .PRIO_BITS(PB), .AGE_LIMIT(AL)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .mstpriority(mstpriority), .mstHSEL(mstHSEL), .mstHADDR(mstHADDR),
        .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE),
        .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
        .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
        .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
        .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
        .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
        .slv_HREADYOUT(slv_HREADYOUT), .slv_HRDATA(slv_HRDATA), .slv_HREADY(slv_HREADY),
        .slv_HRESP(slv_HRESP), .can_switch(can_switch),
        .granted_master(granted_master), .starved(starved)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference state: who owns the port, how long each master has waited,
    // who was last served at each priority level, and the bus ownership mode.
    int m_grant, m_widx;
    int m_age [M];
    int m_last[NLVL];
    bit m_locked, m_idle, m_first;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_grant = 0; m_widx = 0;
        m_locked = 1'b0; m_idle = 1'b1; m_first = 1'b1;
        for (int n = 0; n < M; n++) m_age[n] = 0;
        for (int l = 0; l < NLVL; l++) m_last[l] = 0;
    endtask

    task automatic clear_inputs();
        mstpriority = '0; mstHSEL = '0; mstHADDR = '0; mstHWDATA = '0;
        mstHWRITE = '0; mstHSIZE = '0; mstHBURST = '0; mstHPROT = '0;
        mstHTRANS = '0; mstHMASTLOCK = '0; mstHREADY = '1;
        slv_HRDATA = '0; slv_HREADY = 1'b1; slv_HRESP = 1'b0; can_switch = '0;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        model_reset();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        check("rst_grant", 64'(granted_master), 64'(5'b00001));
        check("rst_starved", 64'(starved), 64'(0));
    endtask

    // One clock edge: predict from the inputs now applied, advance, compare.
    task automatic cycle();
        int eff[M];
        int nage[M];
        int top, pend, nwidx;
        bit any, found, upd, nlocked, nidle, nfirst;
        logic [1:0]   tr, exp_tr;
        logic [M-1:0] exp_st;
        any = 1'b0; top = 0; found = 1'b0;
        for (int n = 0; n < M; n++) begin
            eff[n] = (m_age[n] == AL) ? (1 << PB) : int'(mstpriority[n]);
            if (mstHSEL[n]) begin
                if (!any || eff[n] > top) top = eff[n];
                any = 1'b1;
            end
        end
        pend = m_grant;
        if (any) begin
            for (int k = 1; k <= M; k++) begin
                int c;
                c = (m_last[top] + k) % M;
                if (!found && mstHSEL[c] && eff[c] == top) begin
                    pend = c; found = 1'b1;
                end
            end
        end
        upd = slv_HREADY && !m_locked && (can_switch[m_grant] || m_idle);
        for (int n = 0; n < M; n++)
            nage[n] = (!mstHSEL[n] || n == m_grant) ? 0 : ((m_age[n] < AL) ? m_age[n] + 1 : AL);
        if (m_locked) begin
            nlocked = !(slv_HREADY && !mstHMASTLOCK[m_grant]);
            nidle   = 1'b0;
        end else begin
            nlocked = slv_HREADY && mstHMASTLOCK[m_grant];
            nidle   = !nlocked && !mstHSEL[m_grant];
        end
        nfirst = m_first;
        if (upd && pend != m_grant) nfirst = 1'b1;
        else if (slv_HREADY && mstHSEL[m_grant] && mstHTRANS[m_grant][1]) nfirst = 1'b0;
        nwidx = slv_HREADY ? m_grant : m_widx;

        @(posedge HCLK);
        #1;
        if (upd) begin
            if (any) m_last[top] = pend;
            m_grant = pend;
        end
        for (int n = 0; n < M; n++) m_age[n] = nage[n];
        m_locked = nlocked; m_idle = nidle; m_first = nfirst; m_widx = nwidx;
        cyc++;

        exp_st = '0;
        for (int n = 0; n < M; n++) exp_st[n] = (m_age[n] == AL);
        tr     = mstHTRANS[m_grant];
        exp_tr = (m_first && tr == 2'b11) ? 2'b10 : tr;
        check("grant", 64'(granted_master), 64'(M'(1) << m_grant));
        check("starved", 64'(starved), 64'(exp_st));
        check("haddr", slv_HADDR, mstHADDR[m_grant]);
        check("htrans", 64'(slv_HTRANS), 64'(exp_tr));
        check("hwdata", slv_HWDATA, mstHWDATA[m_widx]);
        check("hsel", 64'(slv_HSEL), 64'(mstHSEL[m_grant]));
        check("hmastlock", 64'(slv_HMASTLOCK), 64'(mstHMASTLOCK[m_grant]));
        check("hreadyout", 64'(slv_HREADYOUT), 64'(mstHREADY[m_grant]));
        check("hrdata", mstHRDATA, slv_HRDATA);
        $display("cyc %0d grant=%b starved=%b htrans=%b", cyc, granted_master, starved, slv_HTRANS);
    endtask

    initial begin
        // Highest priority requester wins one cycle later.
        clear_inputs(); do_reset();
        mstHSEL = 5'b01010; mstpriority[1] = 3'd2; mstpriority[3] = 3'd5; can_switch = '1;
        cycle(); check("prio_pick", 64'(granted_master), 64'(5'b01000));

        // Equal priorities rotate 0 -> 2 -> 4 -> 0.
        clear_inputs(); do_reset();
        mstHSEL = 5'b10101; mstpriority[0] = 3'd3; mstpriority[2] = 3'd3; mstpriority[4] = 3'd3;
        can_switch = '1;
        cycle(); check("rr_1", 64'(granted_master), 64'(5'b00100));
        cycle(); check("rr_2", 64'(granted_master), 64'(5'b10000));
        cycle(); check("rr_3", 64'(granted_master), 64'(5'b00001));

        // Low-priority master 0 starves behind master 1, then gets promoted.
        clear_inputs(); do_reset();
        mstHSEL = 5'b00011; mstpriority[0] = 3'd1; mstpriority[1] = 3'd7;
        cycle(); check("starve_owner", 64'(granted_master), 64'(5'b00010));
        for (int i = 0; i < 14; i++) cycle();
        check("starve_before", 64'(starved), 64'(0));
        cycle(); check("starve_hit", 64'(starved), 64'(5'b00001));
        can_switch = 5'b00010;
        cycle(); check("starve_grant", 64'(granted_master), 64'(5'b00001));
        can_switch = '0;
        cycle(); check("starve_clear", 64'(starved), 64'(0));

        // Lock holds the grant against a higher-priority requester.
        clear_inputs(); do_reset();
        mstHSEL = 5'b00100; mstpriority[2] = 3'd1; can_switch = '1;
        cycle(); check("lock_owner", 64'(granted_master), 64'(5'b00100));
        mstHMASTLOCK[2] = 1'b1;
        cycle();
        mstHSEL[4] = 1'b1; mstpriority[4] = 3'd6;
        for (int i = 0; i < 3; i++) begin
            cycle(); check("lock_hold", 64'(granted_master), 64'(5'b00100));
        end
        mstHMASTLOCK[2] = 1'b0; slv_HREADY = 1'b0;
        cycle(); check("lock_wait_ready", 64'(granted_master), 64'(5'b00100));
        slv_HREADY = 1'b1;
        cycle(); check("lock_exit", 64'(granted_master), 64'(5'b00100));
        cycle(); check("lock_switch", 64'(granted_master), 64'(5'b10000));

        // SEQ from a new owner is restarted as NONSEQ; write data lags a beat.
        clear_inputs(); do_reset();
        mstHSEL = 5'b00100; mstpriority[2] = 3'd4; mstHTRANS[2] = 2'b11; can_switch = '1;
        mstHWDATA[0] = 64'h1111_2222_3333_4444; mstHWDATA[2] = 64'hA5A5_5A5A_DEAD_BEEF;
        cycle();
        check("seq_first", 64'(slv_HTRANS), 64'(2'b10));
        check("wdata_old", slv_HWDATA, 64'h1111_2222_3333_4444);
        cycle();
        check("seq_next", 64'(slv_HTRANS), 64'(2'b11));
        check("wdata_new", slv_HWDATA, 64'hA5A5_5A5A_DEAD_BEEF);

        // Lock beats starvation; asynchronous reset mid-lock clears everything.
        clear_inputs(); do_reset();
        mstHSEL = 5'b00010; mstpriority[1] = 3'd3; mstHMASTLOCK[1] = 1'b1; can_switch = '1;
        cycle(); cycle();
        mstHSEL[3] = 1'b1;
        for (int i = 0; i < 16; i++) cycle();
        check("lock_vs_starve_st", 64'(starved), 64'(5'b01000));
        check("lock_vs_starve_gr", 64'(granted_master), 64'(5'b00010));
        slv_HREADY = 1'b0;
        cycle();
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        check("async_rst_grant", 64'(granted_master), 64'(5'b00001));
        check("async_rst_starved", 64'(starved), 64'(0));
        @(negedge HCLK);
        HRESETn = 1'b1; slv_HREADY = 1'b1;
        cycle(); check("post_rst_idle", 64'(granted_master), 64'(5'b00010));

        // Randomized traffic against the model.
        clear_inputs(); do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < M; n++) begin
                mstHSEL[n]      = ($urandom_range(0, 9) < 6);
                mstpriority[n]  = PB'($urandom_range(0, 7));
                mstHADDR[n]     = {$urandom, $urandom};
                mstHWDATA[n]    = {$urandom, $urandom};
                mstHWRITE[n]    = 1'($urandom_range(0, 1));
                mstHSIZE[n]     = 3'($urandom_range(0, 7));
                mstHBURST[n]    = 3'($urandom_range(0, 7));
                mstHPROT[n]     = 4'($urandom_range(0, 15));
                mstHTRANS[n]    = 2'($urandom_range(0, 3));
                mstHMASTLOCK[n] = ($urandom_range(0, 7) == 0);
                mstHREADY[n]    = 1'($urandom_range(0, 1));
                can_switch[n]   = 1'($urandom_range(0, 1));
            end
            slv_HREADY = ($urandom_range(0, 3) != 0);
            slv_HRESP  = 1'($urandom_range(0, 1));
            slv_HRDATA = {$urandom, $urandom};
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/peripheral_msi_slave_port_qos_ahb4.md
PERIPHERAL_MSI_SLAVE_PORT_QOS_AHB4 -- requirements
Module: peripheral_msi_slave_port_qos_ahb4

Interface
REQ-001 SHALL have parameter PLEN, default 64, address width.
REQ-002 SHALL have parameter XLEN, default 64, data width.
REQ-003 SHALL have parameter MASTERS, default 5, number of requesting masters (>=2).
REQ-004 SHALL have parameter PRIO_BITS, default 3, width of each priority field.
REQ-005 SHALL have parameter AGE_LIMIT, default 15, wait cycles before starvation promotion (>=1).
REQ-006 SHALL have one clock and an asynchronous active-low reset: HCLK input 1, HRESETn input 1.
REQ-007 SHALL have ports: mstpriority in [MASTERS][PRIO_BITS]; mstHSEL in [MASTERS]; mstHADDR in [MASTERS][PLEN]; mstHWDATA in [MASTERS][XLEN]; mstHWRITE in [MASTERS]; mstHSIZE, mstHBURST in [MASTERS][3]; mstHPROT in [MASTERS][4]; mstHTRANS in [MASTERS][2]; mstHMASTLOCK, mstHREADY in [MASTERS].
REQ-008 SHALL have ports: mstHRDATA out XLEN; mstHREADYOUT out 1; mstHRESP out 1.
REQ-009 SHALL have ports: slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADYOUT out 1; slv_HADDR out PLEN; slv_HWDATA out XLEN; slv_HSIZE, slv_HBURST out 3; slv_HPROT out 4; slv_HTRANS out 2; slv_HRDATA in XLEN; slv_HREADY, slv_HRESP in 1.
REQ-010 SHALL have ports: can_switch in [MASTERS]; granted_master out [MASTERS] one-hot; starved out [MASTERS], masters currently age-promoted.

Function
REQ-011 Arbitration SHALL pick the highest effective priority among masters with mstHSEL=1; effective priority = all-ones-plus-one (above every level) if starved, else mstpriority.
REQ-012 Ties SHALL resolve round-robin, starting after the last master granted at that effective level; one last-granted record per level plus one for the starved class.
REQ-013 With no requester, the pending master SHALL equal the current grant (no switch).
REQ-014 FSM states: IDLE (granted master HSEL=0), OWNED, LOCKED; IDLE/OWNED -> LOCKED when granted slv_HMASTLOCK=1 and slv_HREADY=1; LOCKED -> OWNED when HMASTLOCK=0 and slv_HREADY=1.
REQ-015 Grant SHALL update at HCLK edge only when slv_HREADY=1, state != LOCKED, and (can_switch[granted]=1 or state=IDLE).
REQ-016 Address-phase outputs SHALL mux from granted_master index, registered same edge as granted_master (1 cycle arbitration latency).
REQ-017 slv_HWDATA SHALL mux from the index delayed one slv_HREADY-qualified cycle.
REQ-018 On the first address phase after a grant change, slv_HTRANS=SEQ (2'b11) SHALL be driven as NONSEQ (2'b10); BUSY/IDLE/NONSEQ pass unchanged.
REQ-019 Per-master age counter: increments each cycle HSEL=1 and not granted, saturates at AGE_LIMIT, clears when granted or HSEL=0; starved[n]=counter==AGE_LIMIT.
REQ-020 Counter width SHALL be $clog2(AGE_LIMIT+1); no wrap.
REQ-021 mstHRDATA=slv_HRDATA, mstHREADYOUT=slv_HREADY, mstHRESP=slv_HRESP combinationally; slv_HREADYOUT=mstHREADY[granted].
REQ-022 Simultaneous starvation and lock: lock SHALL win; starved master waits until LOCKED exits.

Reset
REQ-023 On HRESETn=0: granted_master=1 (master 0), grant index and delayed index=0, state=IDLE, all age counters=0, starved=0, last-granted records=master 0, first-phase flag=1.

Structure
REQ-024 Package peripheral_msi_ahb4_pkg SHALL hold HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and the FSM state enum.
REQ-025 Round-robin selection SHALL be a sub-module peripheral_msi_rr_select_ahb4 (pending vector, last one-hot -> next one-hot).

Verification
REQ-026 Masters 1,3 HSEL, prio 2 and 5, can_switch=1 -> grant master 3 one cycle later.
REQ-027 Masters 0,2,4 equal prio, continuously requesting, can_switch=1 each cycle -> grants cycle 0,2,4,0.
REQ-028 Master 1 prio 7 continuous, master 0 prio 1, AGE_LIMIT=15 -> starved[0] after 15 waits, master 0 granted next switch, counter cleared.
REQ-029 Granted master HMASTLOCK=1 four cycles, higher-prio master requests -> no switch until lock drops with slv_HREADY=1.
REQ-030 Switch to master 2 driving HTRANS=SEQ -> slv_HTRANS=NONSEQ first beat, SEQ thereafter; slv_HWDATA from master 2 one cycle later.
REQ-031 HRESETn asserted mid-lock with slv_HREADY=0 -> immediate grant=master 0, state IDLE, starved=0.
